mem_io_bridge: RTL and testbench

- Data-memory and memory-mapped I/O stage that sits directly downstream of the processor datapath.
- Consumes the datapath's ALUResult (address), WriteData and the controller's MemWrite; returns ReadData to the datapath's result mux in the same cycle.
- Contains word RAM, LED/switch registers, a free-running timer and a byte TX FIFO with a valid/ready handshake toward a serial transmitter.

---
 rtl/mem_io_bridge.sv | 234 +++++++++++++++++++++++
 tb/tb_mem_io_bridge.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_io_bridge.sv
// mem_io_bridge: data RAM plus memory-mapped LED, switch, timer and TX FIFO.
// Loads are combinational; stores commit on the rising clock edge.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   MemWrite            store strobe for the current cycle
//   ALUResult           byte address (word accesses, low two bits ignored)
//   WriteData           store data
//   ReadData            combinational load data
//   sw / led            switch inputs (synchronized) / LED register
//   tx_data, tx_valid   FIFO head byte and non-empty flag
//   tx_ready            consumer accepts the head byte when valid
//
// Build option: define MMIO_TIMER_EN to include the TIMER/TIMER_CTRL block.
// Without it those two addresses read 0 and ignore writes.
module mem_io_bridge #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 8,
    parameter int LED_W      = 10,
    parameter int SW_W       = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemWrite,
    input  logic [31:0]      ALUResult,
    input  logic [31:0]      WriteData,
    output logic [31:0]      ReadData,
    input  logic [SW_W-1:0]  sw,
    output logic [LED_W-1:0] led,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [31:0]   RAM_BYTES = 32'(RAM_WORDS * 4);
    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

    localparam logic [31:0] A_LED  = 32'hFFFF_0000;
    localparam logic [31:0] A_SW   = 32'hFFFF_0004;
    localparam logic [31:0] A_TMR  = 32'hFFFF_0008;
    localparam logic [31:0] A_CTRL = 32'hFFFF_000C;
    localparam logic [31:0] A_TXD  = 32'hFFFF_0010;
    localparam logic [31:0] A_TXS  = 32'hFFFF_0014;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic          is_ram;
    logic [AW-1:0] ram_idx;

    assign is_ram  = (ALUResult < RAM_BYTES);
    assign ram_idx = ALUResult[AW+1:2];

    // ------------------------------------------------------------------
    // Word RAM (no reset: contents survive a reset pulse)
    // ------------------------------------------------------------------
    logic [31:0] ram_q [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (MemWrite && is_ram) begin
            ram_q[ram_idx] <= WriteData;
        end
    end

    // ------------------------------------------------------------------
    // LED register and switch synchronizer
    // ------------------------------------------------------------------
    logic [LED_W-1:0] led_q, led_d;
    logic [SW_W-1:0]  sw_s1_q, sw_s2_q;

    always_comb begin
        led_d = led_q;
        if (MemWrite && ALUResult == A_LED) begin
            led_d = WriteData[LED_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led_q   <= '0;
            sw_s1_q <= '0;
            sw_s2_q <= '0;
        end else begin
            led_q   <= led_d;
            sw_s1_q <= sw;
            sw_s2_q <= sw_s1_q;
        end
    end

    assign led = led_q;

`ifdef MMIO_TIMER_EN
    // ------------------------------------------------------------------
    // Timer: a store to the count overrides that cycle's increment,
    // and a wrap beats a same-cycle W1C of OVF.
    // ------------------------------------------------------------------
    logic [31:0] tmr_q, tmr_d;
    logic        en_q, en_d;
    logic        ovf_q, ovf_d;
    logic        tmr_wr, ctrl_wr, wrap;

    always_comb begin
        tmr_wr  = MemWrite && (ALUResult == A_TMR);
        ctrl_wr = MemWrite && (ALUResult == A_CTRL);
        wrap    = en_q && !tmr_wr && (tmr_q == 32'hFFFF_FFFF);

        tmr_d = tmr_q;
        if (tmr_wr) begin
            tmr_d = WriteData;
        end else if (en_q) begin
            tmr_d = tmr_q + 32'd1;
        end

        en_d = ctrl_wr ? WriteData[0] : en_q;

        ovf_d = ovf_q;
        if (ctrl_wr && WriteData[1]) begin
            ovf_d = 1'b0;
        end
        if (wrap) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmr_q <= '0;
            en_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            tmr_q <= tmr_d;
            en_q  <= en_d;
            ovf_q <= ovf_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovr_q, ovr_d;
    logic          full, empty, push, pop, accept, drop;

    always_comb begin
        full  = (count_q == DEPTH_C);
        empty = (count_q == '0);
        push  = MemWrite && (ALUResult == A_TXD);
        pop   = !empty && tx_ready;
        // A pop in the same cycle frees the slot being written.
        accept = push && (!full || pop);
        drop   = push && full && !pop;

        wr_ptr_d = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        ovr_d = ovr_q;
        if (MemWrite && (ALUResult == A_TXS) && WriteData[2]) begin
            ovr_d = 1'b0;
        end
        if (drop) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            fifo_q[wr_ptr_q] <= WriteData[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
        end
    end

    assign tx_valid = !empty;
    assign tx_data  = empty ? 8'h00 : fifo_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Load mux
    // ------------------------------------------------------------------
    logic [8:0]  cnt9;
    logic [31:0] tx_status;

    assign cnt9      = 9'(count_q);
    assign tx_status = {16'd0, cnt9[7:0], 5'd0, ovr_q, empty, full};

    always_comb begin
        ReadData = '0;
        if (is_ram) begin
            ReadData = ram_q[ram_idx];
        end else begin
            case (ALUResult)
                A_LED:   ReadData = 32'(led_q);
                A_SW:    ReadData = 32'(sw_s2_q);
`ifdef MMIO_TIMER_EN
                A_TMR:   ReadData = tmr_q;
                A_CTRL:  ReadData = {30'd0, ovf_q, en_q};
`endif
                A_TXS:   ReadData = tx_status;
                default: ReadData = '0;
            endcase
        end
    end

    // Byte-offset bits and the count bit beyond the status field.
    logic unused_ok;
    assign unused_ok = ^{ALUResult[1:0], cnt9[8]};

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed self-checking bench for mem_io_bridge.
// Covers RAM, LED, switch sync, timer (when built in) and the TX FIFO.
module tb_mem_io_bridge;

    localparam logic [31:0] A_LED  = 32'hFFFF_0000;
    localparam logic [31:0] A_SW   = 32'hFFFF_0004;
    localparam logic [31:0] A_TMR  = 32'hFFFF_0008;
    localparam logic [31:0] A_CTRL = 32'hFFFF_000C;
    localparam logic [31:0] A_TXD  = 32'hFFFF_0010;
    localparam logic [31:0] A_TXS  = 32'hFFFF_0014;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [9:0]  sw;
    logic [9:0]  led;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int n_total = 0;
    int n_bad   = 0;

    mem_io_bridge dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .sw        (sw),
        .led       (led),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        ALUResult = a;
        WriteData = d;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a,
                      input logic [31:0] exp);
        MemWrite  = 1'b0;
        ALUResult = a;
        #1;
        chk(tag, ReadData, exp);
    endtask

    initial begin
        reset     = 1'b1;
        MemWrite  = 1'b0;
        ALUResult = '0;
        WriteData = '0;
        sw        = '0;
        tx_ready  = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_led", 32'(led), 32'h0);
        chk("rst_txv", 32'(tx_valid), 32'h0);
        chk("rst_txd", 32'(tx_data), 32'h0);
        rd("rst_led_rd", A_LED, 32'h0);
        rd("rst_txs", A_TXS, 32'h0000_0002);
        rd("rst_tmr", A_TMR, 32'h0);
        rd("rst_ctrl", A_CTRL, 32'h0);

        // RAM
        wr(32'h10, 32'hDEAD_BEEF);
        rd("ram_10", 32'h10, 32'hDEAD_BEEF);
        rd("ram_13", 32'h13, 32'hDEAD_BEEF);
        wr(32'h0, 32'h1111_1111);
        wr(32'h100, 32'h2222_2222);
        rd("ram_0_noalias", 32'h0, 32'h1111_1111);
        rd("ram_past_end", 32'h100, 32'h0);
        wr(32'hFC, 32'hCAFE_F00D);
        rd("ram_last", 32'hFC, 32'hCAFE_F00D);
        rd("ram_10_kept", 32'h10, 32'hDEAD_BEEF);

        // Unmapped and write-only
        wr(32'hFFFF_0020, 32'h1234_5678);
        rd("unmapped", 32'hFFFF_0020, 32'h0);
        rd("txd_reads0", A_TXD, 32'h0);
        rd("txs_no_push", A_TXS, 32'h0000_0002);

        // LED
        wr(A_LED, 32'hFFFF_FFFF);
        chk("led_out", 32'(led), 32'h3FF);
        rd("led_rd", A_LED, 32'h0000_03FF);
        wr(A_LED, 32'h2A5);
        chk("led_out2", 32'(led), 32'h2A5);

        // Switch synchronizer
        sw = 10'h155;
        rd("sw_0cyc", A_SW, 32'h0);
        tick();
        rd("sw_1cyc", A_SW, 32'h0);
        tick();
        rd("sw_2cyc", A_SW, 32'h155);

`ifdef MMIO_TIMER_EN
        wr(A_TMR, 32'hFFFF_FFFE);
        rd("tmr_wr", A_TMR, 32'hFFFF_FFFE);
        wr(A_CTRL, 32'h1);
        rd("tmr_en_edge", A_TMR, 32'hFFFF_FFFE);
        tick();
        rd("tmr_ffff", A_TMR, 32'hFFFF_FFFF);
        rd("ctrl_en", A_CTRL, 32'h1);
        tick();
        rd("tmr_wrap", A_TMR, 32'h0);
        rd("ctrl_ovf", A_CTRL, 32'h3);
        wr(A_CTRL, 32'h3);
        rd("ctrl_clr", A_CTRL, 32'h1);
        rd("tmr_one", A_TMR, 32'h1);
        wr(A_TMR, 32'hFFFF_FFFE);
        rd("tmr_wr_wins", A_TMR, 32'hFFFF_FFFE);
        tick();
        wr(A_CTRL, 32'h3);
        rd("ovf_set_wins", A_CTRL, 32'h3);
        rd("tmr_wrap2", A_TMR, 32'h0);
        wr(A_CTRL, 32'h3);
        rd("ovf_cleared", A_CTRL, 32'h1);
        wr(A_CTRL, 32'h0);
        rd("tmr_stop", A_TMR, 32'h2);
        tick();
        rd("tmr_held", A_TMR, 32'h2);
`else
        wr(A_TMR, 32'h55);
        rd("tmr_absent", A_TMR, 32'h0);
        wr(A_CTRL, 32'h1);
        rd("ctrl_absent", A_CTRL, 32'h0);
        tick();
        rd("tmr_absent2", A_TMR, 32'h0);
`endif

        // FIFO fill, overflow, drain
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr(A_TXD, 32'h0000_AB00 | 32'(8'h41 + i));
        end
        chk("fill_valid", 32'(tx_valid), 32'h1);
        chk("fill_head", 32'(tx_data), 32'h41);
        rd("fill_status", A_TXS, 32'h0000_0801);
        wr(A_TXD, 32'h49);
        rd("ovr_status", A_TXS, 32'h0000_0805);
        chk("ovr_head", 32'(tx_data), 32'h41);
        ALUResult = 32'h0;
        tx_ready  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", 32'(tx_valid), 32'h1);
            chk("drain_data", 32'(tx_data), 32'(8'h41 + i));
            tick();
        end
        chk("drained_valid", 32'(tx_valid), 32'h0);
        rd("drained_status", A_TXS, 32'h0000_0006);
        wr(A_TXS, 32'h4);
        rd("ovr_w1c", A_TXS, 32'h0000_0002);

        // Full FIFO with simultaneous push and pop
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr(A_TXD, 32'(8'h41 + i));
        end
        rd("full2_status", A_TXS, 32'h0000_0801);
        tx_ready = 1'b1;
        wr(A_TXD, 32'h5A);
        tx_ready = 1'b0;
        rd("pushpop_status", A_TXS, 32'h0000_0801);
        chk("pushpop_head", 32'(tx_data), 32'h42);
        ALUResult = 32'h0;
        tx_ready  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("pp_data", 32'(tx_data),
                (i < 7) ? 32'(8'h42 + i) : 32'h5A);
            tick();
        end
        chk("pp_empty", 32'(tx_valid), 32'h0);

        // Push and pop request while empty
        wr(A_TXD, 32'h77);
        chk("emp_pp_valid", 32'(tx_valid), 32'h1);
        chk("emp_pp_data", 32'(tx_data), 32'h77);
        rd("emp_pp_status", A_TXS, 32'h0000_0100);
        tick();
        chk("emp_pp_popped", 32'(tx_valid), 32'h0);

        // Reset with bytes queued
        tx_ready = 1'b0;
        wr(A_TXD, 32'h31);
        wr(A_TXD, 32'h32);
        wr(A_TXD, 32'h33);
        rd("pre_rst_status", A_TXS, 32'h0000_0300);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_valid", 32'(tx_valid), 32'h0);
        chk("rst2_data", 32'(tx_data), 32'h0);
        chk("rst2_led", 32'(led), 32'h0);
        rd("rst2_status", A_TXS, 32'h0000_0002);
        rd("rst2_ram10", 32'h10, 32'hDEAD_BEEF);
        rd("rst2_ramfc", 32'hFC, 32'hCAFE_F00D);
        tick();
        chk("rst2_valid_hold", 32'(tx_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
